// File: rtl/translation_table.sv
// translation_table
//   Symbol-to-code lookup table for the Huffman encoder. There is one entry
//   per 7-bit ASCII symbol, and each entry holds a right-aligned code and its
//   bit length. The tree builder writes one entry per clock. The encoder
//   datapath reads an entry combinationally, indexed by symbol.
//
// Ports
//   clock              in   1       rising-edge clock for writes
//   ctrl_reset         in   1       async active-low reset; clears every entry
//   ctrl_write         in   1       write enable, sampled on the rising edge
//   wrAscii            in   ADDR_W  entry index to write
//   wrCode             in   CODE_W  code bits, LSB-aligned
//   wrCodeLength       in   LEN_W   number of valid code bits (0 = unused)
//   rdAscii            in   ADDR_W  entry index to read
//   data_rdCode        out  CODE_W  stored code of entry rdAscii
//   data_rdCodeLength  out  LEN_W   stored length of entry rdAscii
//
// Interface protocol: there is no valid/ready handshake. A write is accepted
// on every rising edge where ctrl_reset=1 and ctrl_write=1, back-to-back,
// with no busy state. Reads are pure combinational lookups with no bypass.
// On a read/write collision the old entry is visible until the edge, and the
// new entry is visible from the edge onward.
module translation_table #(
  parameter int ADDR_W = 7,
  parameter int CODE_W = 128,
  parameter int LEN_W  = 7
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_write,
  input  logic [ADDR_W-1:0] wrAscii,
  input  logic [CODE_W-1:0] wrCode,
  input  logic [LEN_W-1:0]  wrCodeLength,
  input  logic [ADDR_W-1:0] rdAscii,
  output logic [CODE_W-1:0] data_rdCode,
  output logic [LEN_W-1:0]  data_rdCodeLength
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [CODE_W-1:0] codeMem [DEPTH];
  logic [LEN_W-1:0]  lenMem  [DEPTH];

  // Keep only the low wrCodeLength bits of the incoming code. Stored codes
  // therefore never carry stale upper bits, and downstream shifters can
  // consume them without re-masking.
  logic [CODE_W-1:0] wrMask;
  logic [CODE_W-1:0] wrCodeMasked;

  always_comb begin
    wrMask = '0;
    for (int i = 0; i < CODE_W; i++) begin
      wrMask[i] = (i < int'(wrCodeLength));
    end
    wrCodeMasked = wrCode & wrMask;
  end

  // Reset is asynchronous, so the whole table reads zero as soon as
  // ctrl_reset falls. Any write that is pending when reset asserts is lost.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      for (int e = 0; e < DEPTH; e++) begin
        codeMem[e] <= '0;
        lenMem[e]  <= '0;
      end
    end else if (ctrl_write) begin
      codeMem[wrAscii] <= wrCodeMasked;
      lenMem[wrAscii]  <= wrCodeLength;
    end
  end

  assign data_rdCode       = codeMem[rdAscii];
  assign data_rdCodeLength = lenMem[rdAscii];

endmodule

// File: tb/tb_translation_table.sv
module tb_translation_table;

  localparam int ADDR_W = 7;
  localparam int CODE_W = 128;
  localparam int LEN_W  = 7;
  localparam int DEPTH  = 128;

  logic              clock;
  logic              ctrl_reset;
  logic              ctrl_write;
  logic [ADDR_W-1:0] wrAscii;
  logic [CODE_W-1:0] wrCode;
  logic [LEN_W-1:0]  wrCodeLength;
  logic [ADDR_W-1:0] rdAscii;
  logic [CODE_W-1:0] data_rdCode;
  logic [LEN_W-1:0]  data_rdCodeLength;

  translation_table #(
    .ADDR_W(ADDR_W),
    .CODE_W(CODE_W),
    .LEN_W (LEN_W)
  ) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_write       (ctrl_write),
    .wrAscii          (wrAscii),
    .wrCode           (wrCode),
    .wrCodeLength     (wrCodeLength),
    .rdAscii          (rdAscii),
    .data_rdCode      (data_rdCode),
    .data_rdCodeLength(data_rdCodeLength)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // behavioural model: the table as two plain arrays
  logic [CODE_W-1:0] model_code [DEPTH];
  logic [LEN_W-1:0]  model_len  [DEPTH];
  logic [CODE_W+LEN_W-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  function automatic logic [CODE_W-1:0] masked(input logic [CODE_W-1:0] c,
                                               input logic [LEN_W-1:0] l);
    if (l == 0) return '0;
    return c & ((128'd1 << l) - 128'd1);
  endfunction

  task automatic model_clear();
    for (int e = 0; e < DEPTH; e++) begin
      model_code[e] = '0;
      model_len[e]  = '0;
    end
  endtask

  task automatic check(input string name,
                       input logic [CODE_W-1:0] act_c, input logic [LEN_W-1:0] act_l,
                       input logic [CODE_W-1:0] exp_c, input logic [LEN_W-1:0] exp_l);
    checks++;
    if (act_c !== exp_c || act_l !== exp_l) begin
      errors++;
      $display("FAIL %s: rdAscii=%0d got code=%h len=%0d, expected code=%h len=%0d",
               name, rdAscii, act_c, act_l, exp_c, exp_l);
    end
  endtask

  // Checks the outputs against the front of exp_q. The expected values are
  // literals pushed by the caller.
  task automatic check_lit(input string name);
    logic [CODE_W+LEN_W-1:0] e;
    e = exp_q.pop_front();
    check(name, data_rdCode, data_rdCodeLength, e[CODE_W+LEN_W-1:LEN_W], e[LEN_W-1:0]);
  endtask

  // One clock edge. The model takes the write that the DUT sampled, then the
  // task returns 1 time unit after the edge, ready for new inputs.
  task automatic step();
    @(posedge clock);
    if (ctrl_reset && ctrl_write) begin
      model_code[wrAscii] = masked(wrCode, wrCodeLength);
      model_len[wrAscii]  = wrCodeLength;
    end
    #1;
  endtask

  task automatic set_write(input logic we, input logic [ADDR_W-1:0] a,
                           input logic [CODE_W-1:0] c, input logic [LEN_W-1:0] l,
                           input logic [ADDR_W-1:0] r);
    ctrl_write   = we;
    wrAscii      = a;
    wrCode       = c;
    wrCodeLength = l;
    rdAscii      = r;
  endtask

  // compare process: checks every falling edge against the model
  always @(negedge clock) begin
    if (cmp_en)
      check("cycle", data_rdCode, data_rdCodeLength, model_code[rdAscii], model_len[rdAscii]);
  end

  initial begin
    logic [CODE_W-1:0] rc;
    ctrl_reset = 1'b1;
    set_write(1'b0, '0, '0, '0, '0);
    model_clear();
    #1 ctrl_reset = 1'b0;
    #1;
    // Test 1: reset state
    rdAscii = 7'd0;  #1; exp_q.push_back({128'd0, 7'd0}); check_lit("reset_rd0");
    rdAscii = 7'd77; #1; exp_q.push_back({128'd0, 7'd0}); check_lit("reset_rd77");
    cmp_en = 1'b1;
    step();
    step();
    ctrl_reset = 1'b1;
    step();

    // Test 2: basic write/read
    set_write(1'b1, 7'd1, 128'd1, 7'd2, 7'd1);
    step();
    exp_q.push_back({128'd1, 7'd2}); check_lit("basic");

    // Test 3: code bits above the length are masked off
    set_write(1'b1, 7'h41, 128'hFF, 7'd3, 7'h41);
    step();
    exp_q.push_back({128'd7, 7'd3}); check_lit("mask");

    // Test 4: back-to-back writes to entries 0 and 127; entry 1 is untouched
    set_write(1'b1, 7'd0, 128'd5, 7'd3, 7'd0);
    step();
    set_write(1'b1, 7'd127, 128'h2, 7'd2, 7'd0);
    step();
    ctrl_write = 1'b0;
    rdAscii = 7'd0;   #1; exp_q.push_back({128'd5, 7'd3}); check_lit("iso_e0");
    rdAscii = 7'd127; #1; exp_q.push_back({128'd2, 7'd2}); check_lit("iso_e127");
    rdAscii = 7'd1;   #1; exp_q.push_back({128'd1, 7'd2}); check_lit("iso_e1");
    step();

    // Test 5: read/write collision on entry 9
    set_write(1'b1, 7'd9, 128'd3, 7'd2, 7'd9);
    step();
    set_write(1'b1, 7'd9, 128'd6, 7'd3, 7'd9);
    #2; exp_q.push_back({128'd3, 7'd2}); check_lit("collide_before");
    step();
    exp_q.push_back({128'd6, 7'd3}); check_lit("collide_after");

    // Length 127 keeps bits 126:0 and drops bit 127
    set_write(1'b1, 7'd20, {128{1'b1}}, 7'd127, 7'd20);
    step();
    exp_q.push_back({1'b0, {127{1'b1}}, 7'd127}); check_lit("len127");

    // Length 0 stores an empty entry whatever the code bits are
    set_write(1'b1, 7'd21, 128'hABCD, 7'd0, 7'd21);
    step();
    exp_q.push_back({128'd0, 7'd0}); check_lit("len0");

    // Randomized traffic, scored by the compare process
    for (int n = 0; n < 400; n++) begin
      rc = {$urandom, $urandom, $urandom, $urandom};
      set_write(($urandom_range(0, 3) != 0), 7'($urandom_range(0, 127)), rc,
                7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
      if ($urandom_range(0, 4) == 0) rdAscii = wrAscii;
      step();
    end
    // Sweep every entry so a write to the wrong address shows up
    ctrl_write = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      rdAscii = 7'(e);
      step();
    end

    // Test 6: reset pulse between edges, including a write attempt while it is low
    set_write(1'b0, '0, '0, '0, 7'd9);
    ctrl_reset = 1'b0;
    model_clear();
    #1; exp_q.push_back({128'd0, 7'd0}); check_lit("midreset_e9");
    rdAscii = 7'd20; #1; exp_q.push_back({128'd0, 7'd0}); check_lit("midreset_e20");
    set_write(1'b1, 7'd5, 128'h1F, 7'd5, 7'd5);
    step();
    exp_q.push_back({128'd0, 7'd0}); check_lit("write_in_reset");
    #2 ctrl_reset = 1'b1;
    ctrl_write = 1'b0;
    step();
    exp_q.push_back({128'd0, 7'd0}); check_lit("after_reset");
    for (int n = 0; n < 100; n++) begin
      rc = {$urandom, $urandom, $urandom, $urandom};
      set_write(1'b1, 7'($urandom_range(0, 127)), rc,
                7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
      step();
    end
    ctrl_write = 1'b0;
    step();
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
